// File: rtl/sprite_move_scheduler_if.sv
// Updater bus between the sprite scheduler (master) and the shared position updater (slave).
interface sprite_move_scheduler_if #(
    parameter int X_W = 11,
    parameter int Y_W = 10
);
    logic           upd_valid;
    logic [2:0]     upd_sprite;
    logic [X_W-1:0] upd_pos_x;
    logic [Y_W-1:0] upd_pos_y;
    logic [3:0]     upd_dir;
    logic [X_W-1:0] upd_new_x;
    logic [Y_W-1:0] upd_new_y;

    modport master (
        output upd_valid, upd_sprite, upd_pos_x, upd_pos_y, upd_dir,
        input  upd_new_x, upd_new_y
    );
    modport slave (
        input  upd_valid, upd_sprite, upd_pos_x, upd_pos_y, upd_dir,
        output upd_new_x, upd_new_y
    );
endinterface

// File: rtl/sprite_move_scheduler.sv
// Round-robin scheduler sharing one sprite position updater across all sprites.
// Optional pacman/ghost hit detection is enabled by defining SCHED_COLLIDE_EN.
module sprite_move_scheduler #(
    parameter int NUM_SPRITES = 5,
    parameter int UPD_LATENCY = 2,
    parameter int X_W         = 11,
    parameter int Y_W         = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tick,
    input  logic [4*NUM_SPRITES-1:0]   dir_req,
    input  logic [X_W*NUM_SPRITES-1:0] init_pos_x,
    input  logic [Y_W*NUM_SPRITES-1:0] init_pos_y,
    sprite_move_scheduler_if.master    upd,
    output logic [X_W*NUM_SPRITES-1:0] pos_x,
    output logic [Y_W*NUM_SPRITES-1:0] pos_y,
    output logic                       busy,
    output logic                       round_done,
    output logic                       overrun,
    output logic [NUM_SPRITES-1:0]     collide
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam logic [3:0] LAT_M1    = 4'(UPD_LATENCY - 1);
    localparam logic [2:0] LAST      = 3'(NUM_SPRITES - 1);

    logic [2:0] state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [NUM_SPRITES-1:0][3:0]     dir_q, dir_d, dir_clean;
    logic [NUM_SPRITES-1:0][X_W-1:0] px_q, px_d;
    logic [NUM_SPRITES-1:0][Y_W-1:0] py_q, py_d;
    logic [2:0]     upd_sprite_q;
    logic [X_W-1:0] upd_px_q;
    logic [Y_W-1:0] upd_py_q;
    logic [3:0]     upd_dir_q;
    logic           overrun_q;

    // Anything that is not exactly one direction means "hold still".
    always_comb begin
        for (int i = 0; i < NUM_SPRITES; i++)
            dir_clean[i] = $onehot(dir_req[4*i +: 4]) ? dir_req[4*i +: 4] : 4'b0000;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        px_d    = px_q;
        py_d    = py_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (tick) begin
                    dir_d   = dir_clean;
                    idx_d   = 3'd0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = 4'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAT_M1) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                px_d[idx_q] = upd.upd_new_x;
                py_d[idx_q] = upd.upd_new_y;
                if (idx_q == LAST) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = S_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_CAPTURE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= 3'd0;
            cnt_q        <= 4'd0;
            dir_q        <= '0;
            px_q         <= init_pos_x;
            py_q         <= init_pos_y;
            upd_sprite_q <= 3'd0;
            upd_px_q     <= '0;
            upd_py_q     <= '0;
            upd_dir_q    <= 4'd0;
            overrun_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            px_q    <= px_d;
            py_q    <= py_d;
            // Issue operands are latched once and held through WAIT and CAPTURE.
            if (state_d == S_ISSUE) begin
                upd_sprite_q <= idx_d;
                upd_px_q     <= px_q[idx_d];
                upd_py_q     <= py_q[idx_d];
                upd_dir_q    <= dir_d[idx_d];
            end
            if (tick && busy) overrun_q <= 1'b1;
        end
    end

`ifdef SCHED_COLLIDE_EN
    logic [NUM_SPRITES-1:0] hit_q, hit_d, collide_q;

    always_comb begin
        hit_d = hit_q;
        if ((state_q == S_IDLE || state_q == S_DONE) && tick)
            hit_d = '0;
        else if (state_q == S_CAPTURE && idx_q != 3'd0 &&
                 upd.upd_new_x == px_q[0] && upd.upd_new_y == py_q[0])
            hit_d[idx_q] = 1'b1;
    end

    // Loaded at the last CAPTURE edge so the mask is visible from the DONE cycle on.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q     <= '0;
            collide_q <= '0;
        end else begin
            hit_q <= hit_d;
            if (state_q == S_CAPTURE && idx_q == LAST) collide_q <= hit_d;
        end
    end
    assign collide = collide_q;
`else
    assign collide = '0;
`endif

    assign upd.upd_valid  = (state_q == S_ISSUE);
    assign upd.upd_sprite = upd_sprite_q;
    assign upd.upd_pos_x  = upd_px_q;
    assign upd.upd_pos_y  = upd_py_q;
    assign upd.upd_dir    = upd_dir_q;
    assign pos_x          = px_q;
    assign pos_y          = py_q;
    assign round_done     = (state_q == S_DONE);
    assign overrun        = overrun_q;
endmodule

// File: tb/tb_sprite_move_scheduler.sv
// Bench for sprite_move_scheduler: directed scenarios then random ticks/directions/resets,
// checked every cycle against a round-offset based reference model.
module tb_sprite_move_scheduler;
    localparam int N    = 5;
    localparam int L    = 2;
    localparam int XW   = 11;
    localparam int YW   = 10;
    localparam int SLOT = L + 2;
    localparam int R    = N * SLOT;

    logic          clk = 1'b0, rst = 1'b0, tick = 1'b0;
    logic [4*N-1:0]  dir_req = '0;
    logic [XW*N-1:0] init_x = '0, pos_x;
    logic [YW*N-1:0] init_y = '0, pos_y;
    logic            busy, round_done, overrun;
    logic [N-1:0]    collide;

    sprite_move_scheduler_if #(.X_W(XW), .Y_W(YW)) uif ();

    sprite_move_scheduler #(.NUM_SPRITES(N), .UPD_LATENCY(L), .X_W(XW), .Y_W(YW)) dut (
        .clk(clk), .rst(rst), .tick(tick), .dir_req(dir_req),
        .init_pos_x(init_x), .init_pos_y(init_y), .upd(uif),
        .pos_x(pos_x), .pos_y(pos_y), .busy(busy), .round_done(round_done),
        .overrun(overrun), .collide(collide)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: round progress is just "cycles since round start".
    bit            mvalid = 0, in_round = 0, upd_zero = 0, m_ovr = 0, force_col = 0;
    int            k = 0;
    logic [XW-1:0] mx [N];
    logic [YW-1:0] my [N];
    logic [3:0]    msnap [N];
    logic [N-1:0]  mhit = '0, mcol = '0;
    logic [XW-1:0] cap_x;
    logic [YW-1:0] cap_y;

    function automatic logic [3:0] clean(input logic [3:0] d);
        return ($countones(d) == 1) ? d : 4'b0000;
    endfunction

    // Behaviour of the external updater seen by the scheduler.
    task automatic upd_fn(input int s, input logic [XW-1:0] x, input logic [YW-1:0] y,
                          input logic [3:0] d, output logic [XW-1:0] nx, output logic [YW-1:0] ny);
        nx = x;
        ny = y;
        case (d)
            4'b0001: nx = x + XW'(16);
            4'b1000: nx = x - XW'(16);
            4'b0010: ny = y - YW'(16);
            4'b0100: ny = y + YW'(16);
            default: ;
        endcase
        if (force_col && s <= 1) begin
            nx = XW'(320);
            ny = YW'(400);
        end
    endtask

    task automatic cyc();
        bit act;
        int slot, ph;
        @(negedge clk);
        act  = in_round && k >= 1 && k <= R;
        slot = act ? (k - 1) / SLOT : 0;
        ph   = act ? (k - 1) % SLOT : 0;
        // Result is only meaningful in the capture cycle; junk elsewhere.
        if (act && ph == SLOT - 1) begin
            upd_fn(slot, mx[slot], my[slot], msnap[slot], cap_x, cap_y);
            uif.upd_new_x = cap_x;
            uif.upd_new_y = cap_y;
        end else begin
            uif.upd_new_x = XW'($urandom);
            uif.upd_new_y = YW'($urandom);
        end
        if (mvalid) begin
            chk("busy", 32'(busy), 32'(act));
            chk("upd_valid", 32'(uif.upd_valid), 32'(act && ph == 0));
            chk("round_done", 32'(round_done), 32'(in_round && k == R + 1));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            chk("collide", 32'(collide), 32'(mcol));
            for (int i = 0; i < N; i++) begin
                chk($sformatf("pos_x[%0d]", i), 32'(pos_x[i*XW +: XW]), 32'(mx[i]));
                chk($sformatf("pos_y[%0d]", i), 32'(pos_y[i*YW +: YW]), 32'(my[i]));
            end
            if (act) begin
                chk("upd_sprite", 32'(uif.upd_sprite), 32'(slot));
                chk("upd_pos_x", 32'(uif.upd_pos_x), 32'(mx[slot]));
                chk("upd_pos_y", 32'(uif.upd_pos_y), 32'(my[slot]));
                chk("upd_dir", 32'(uif.upd_dir), 32'(msnap[slot]));
            end else if (upd_zero) begin
                chk("upd_sprite_rst", 32'(uif.upd_sprite), 32'd0);
                chk("upd_pos_x_rst", 32'(uif.upd_pos_x), 32'd0);
                chk("upd_pos_y_rst", 32'(uif.upd_pos_y), 32'd0);
                chk("upd_dir_rst", 32'(uif.upd_dir), 32'd0);
            end
        end
        @(posedge clk);
        if (rst) begin
            mvalid   = 1;
            in_round = 0;
            k        = 0;
            m_ovr    = 0;
            mcol     = '0;
            upd_zero = 1;
            for (int i = 0; i < N; i++) begin
                mx[i] = init_x[i*XW +: XW];
                my[i] = init_y[i*YW +: YW];
            end
        end else begin
            if (act && ph == SLOT - 1) begin
                mx[slot] = cap_x;
                my[slot] = cap_y;
`ifdef SCHED_COLLIDE_EN
                if (slot > 0 && cap_x == mx[0] && cap_y == my[0]) mhit[slot] = 1'b1;
                if (slot == N - 1) mcol = mhit;
`endif
            end
            if (tick && !act) begin
                in_round = 1;
                k        = 1;
                mhit     = '0;
                upd_zero = 0;
                for (int i = 0; i < N; i++) msnap[i] = clean(dir_req[4*i +: 4]);
            end else begin
                if (tick) m_ovr = 1;
                if (in_round) begin
                    k++;
                    if (k > R + 1) in_round = 0;
                end
            end
        end
        #1;
    endtask

    function automatic logic [3:0] rand_dir();
        logic [3:0] oh;
        oh = 4'b0001 << $urandom_range(0, 3);
        return ($urandom_range(0, 1) == 0) ? oh : 4'($urandom);
    endfunction

    initial begin
        uif.upd_new_x = '0;
        uif.upd_new_y = '0;
        for (int i = 0; i < N; i++) begin
            init_x[i*XW +: XW] = XW'($urandom);
            init_y[i*YW +: YW] = YW'($urandom);
        end
        init_x[0 +: XW]    = XW'(624);
        init_y[0 +: YW]    = YW'(32);
        init_x[2*XW +: XW] = XW'(272);

        rst = 1'b1; cyc(); cyc(); rst = 1'b0;
        cyc();

        // Sprite 2 RIGHT, sprite 1 illegal 0011.
        dir_req = {4'b1000, 4'b0100, 4'b0001, 4'b0011, 4'b0010};
        tick = 1'b1; cyc(); tick = 1'b0;
        repeat (R + 3) cyc();

        // Second tick at T+10 lands mid-round.
        tick = 1'b1; cyc(); tick = 1'b0;
        repeat (9) cyc();
        tick = 1'b1; cyc(); tick = 1'b0;
        repeat (R) cyc();

        // Reset at T+7 aborts the round.
        tick = 1'b1; cyc(); tick = 1'b0;
        repeat (6) cyc();
        rst = 1'b1; cyc(); rst = 1'b0;
        repeat (5) cyc();

        // Pacman and blinky land on the same square.
        force_col = 1'b1;
        tick = 1'b1; cyc(); tick = 1'b0;
        repeat (R + 3) cyc();
        force_col = 1'b0;

        // Back-to-back tick accepted in the DONE cycle.
        tick = 1'b1; cyc(); tick = 1'b0;
        repeat (R) cyc();
        tick = 1'b1; cyc(); tick = 1'b0;
        repeat (R + 2) cyc();

        repeat (1500) begin
            for (int i = 0; i < N; i++) dir_req[4*i +: 4] = rand_dir();
            tick      = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 299) == 0);
            force_col = ($urandom_range(0, 3) == 0);
            if (rst) begin
                for (int i = 0; i < N; i++) begin
                    init_x[i*XW +: XW] = XW'($urandom);
                    init_y[i*YW +: YW] = YW'($urandom);
                end
            end
            cyc();
        end
        tick = 1'b0;
        rst  = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sprite_move_scheduler.md
# sprite_move_scheduler

Time-multiplexes the single shared sprite position-update datapath between the five game sprites (pacman 0, blinky 1, pinky 2, inky 3, clyde 4). On each game tick it snapshots every sprite's requested direction, then issues the sprites one at a time, in index order, to the updater. It captures each returned position into its own position register file. It sits between the input/AI direction sources and the renderer, and is the sole owner of the authoritative sprite positions.

## Interface
- NUM_SPRITES, 5, number of sprites served; index 0 is pacman.
- UPD_LATENCY, 2, cycles from the updater issue strobe to a valid updater result; legal range is 1 to 15.
- X_W, 11, x-coordinate width.
- Y_W, 10, y-coordinate width.
- clk  in  1  system clock; the only clock in the block.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  single-cycle round-start pulse.
- dir_req  in  4*NUM_SPRITES  packed one-hot directions; sprite i occupies [4i+3:4i]; RIGHT=0001, UP=0010, DOWN=0100, LEFT=1000.
- init_pos_x  in  X_W*NUM_SPRITES  packed reset x positions.
- init_pos_y  in  Y_W*NUM_SPRITES  packed reset y positions.
- upd_valid  out  1  issue strobe to the updater.
- upd_sprite  out  3  index of the sprite being updated.
- upd_pos_x  out  X_W  current x of the issued sprite.
- upd_pos_y  out  Y_W  current y of the issued sprite.
- upd_dir  out  4  direction of the issued sprite.
- upd_new_x  in  X_W  updater result x.
- upd_new_y  in  Y_W  updater result y.
- pos_x  out  X_W*NUM_SPRITES  packed authoritative x positions.
- pos_y  out  Y_W*NUM_SPRITES  packed authoritative y positions.
- busy  out  1  a round is in progress.
- round_done  out  1  single-cycle pulse when a round completes.
- overrun  out  1  sticky flag: a tick arrived while busy.
- collide  out  NUM_SPRITES  per-sprite hit mask; bit 0 is always 0.

## Operation
- Reset behaviour, sampled on every clk edge while rst=1:
  - pos_x and pos_y load init_pos_x and init_pos_y.
  - State goes to IDLE and the sprite index goes to 0.
  - upd_valid=0, upd_sprite=0, upd_pos_x=0, upd_pos_y=0, upd_dir=0.
  - busy=0, round_done=0, overrun=0, collide=0.
- IDLE:
  - On tick=1, snapshot dir_req into an internal direction register.
  - Any sprite field that is not one-hot (including 0000) is stored as 0000, meaning hold.
  - Set index to 0 and go to ISSUE.
- ISSUE (1 cycle):
  - upd_valid=1.
  - upd_sprite, upd_pos_x, upd_pos_y and upd_dir are driven from the index, the position register file and the snapshot.
  - Go to WAIT with the wait counter set to 0.
- WAIT (UPD_LATENCY cycles):
  - upd_valid=0; all other upd_* outputs stay stable.
  - The counter increments each cycle; when it reaches UPD_LATENCY-1, go to CAPTURE.
- CAPTURE (1 cycle):
  - upd_* outputs stay stable.
  - upd_new_x and upd_new_y are written into pos[index] at the end of the cycle.
  - If index==NUM_SPRITES-1, go to DONE; otherwise increment index and go to ISSUE.
- DONE (1 cycle):
  - round_done=1 and busy=0.
  - Return to IDLE. A tick arriving in this cycle is accepted, as in IDLE.
- busy=1 in ISSUE, WAIT and CAPTURE.
- A tick in any busy state is ignored, and overrun is set. overrun clears only on rst.
- Updater results are taken verbatim. Wrap-around and wall checks belong to the updater; the scheduler does no arithmetic on positions.
- pos_x and pos_y change only in CAPTURE, one sprite per round slot. A sprite's new position is visible to the renderer in the cycle after its CAPTURE.
- Reset asserted mid-round aborts the round:
  - No CAPTURE write occurs in the reset cycle.
  - Positions reload from init_pos_x and init_pos_y.
  - round_done is not pulsed.

## Timing
- A tick sampled at the edge ending cycle T makes ISSUE of sprite 0 occur in cycle T+1.
- Each sprite slot takes UPD_LATENCY+2 cycles.
- A full round takes NUM_SPRITES*(UPD_LATENCY+2) cycles. With the defaults that is 20 cycles (busy over cycles T+1 to T+20), with round_done in cycle T+21.
- The minimum tick period without overrun is NUM_SPRITES*(UPD_LATENCY+2)+1 cycles.
- Sprite i's CAPTURE is in cycle T+(i+1)*(UPD_LATENCY+2).

## Configuration
- Macro: SCHED_COLLIDE_EN.
- Defined:
  - During the CAPTURE of each ghost (index ≥1), its new position is compared for equality against pos[0] (pacman's position captured earlier in the same round).
  - Each match sets the corresponding bit in an internal hit mask.
  - collide is registered from the mask in the DONE cycle and holds until the next DONE cycle or rst.
  - The mask clears at round start.
- Not defined: collide is constant 0 and no comparators are synthesized.

## Test plan
- Reset: apply rst for 2 cycles with init x/y of sprite 0 = (624, 32) -> pos[0]=(624, 32), all other outputs 0, busy=0.
- Single round: tick with sprite 2 set to RIGHT and the updater model returning x+16 -> upd_valid pulses 5 times, 4 cycles apart, starting at T+1; pos[2].x goes from 272 to 288 at T+13; round_done at T+21.
- Overrun: tick at T and again at T+10 -> second tick ignored, overrun=1 and sticky, round_done only at T+21.
- Illegal direction: dir_req field of 0011 for sprite 1 -> upd_dir=0000 in sprite 1's ISSUE cycle.
- Reset mid-round: assert rst at T+7 -> positions reload from init, busy=0, no round_done pulse.
- Collision (SCHED_COLLIDE_EN defined): updater model returns pacman=(320, 400) and blinky=(320, 400) -> collide=00010 from T+21.
